// File: rtl/regfile_write_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sched_pkg
// Brief    : Shared types and constants for the register-file write scheduler
// Revision : 1.0 - initial release
// ============================================================================
package regfile_sched_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    localparam int NREQ = 2;

    // Requester index encoding: bit position in req_valid/req_ready/grant
    localparam int REQ_EXEC = 0;
    localparam int REQ_MEM  = 1;

endpackage : regfile_sched_pkg
`default_nettype wire

// File: rtl/regfile_write_sched_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Combinational two-way round-robin grant (priority held by parent)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import regfile_sched_pkg::*;
(
    input  logic [NREQ-1:0] req_valid_i,
    input  logic            rr_pri_i,
    output logic [NREQ-1:0] grant_o
);

    always_comb begin
        grant_o = '0;
        unique case (req_valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = rr_pri_i ? 2'b10 : 2'b01;
            default: grant_o = '0;
        endcase
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/regfile_write_sched.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_sched
// Brief    : Shares the register-file write port between two writeback
//            requesters after zeroing every register following reset
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_sched
    import regfile_sched_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REGNO = 32,
    parameter int AW    = $clog2(REGNO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [AW-1:0]    req_addr_0,
    input  logic [AW-1:0]    req_addr_1,
    input  logic [WIDTH-1:0] req_data_0,
    input  logic [WIDTH-1:0] req_data_1,
    output logic             init_busy,
    output logic [NREQ-1:0]  grant,
    output logic             rf_we,
    output logic [WIDTH-1:0] rf_w_addr,
    output logic [WIDTH-1:0] rf_in
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(REGNO - 1);

    sched_state_t     state_q;
    logic [AW-1:0]    init_cnt_q;
    logic [AW-1:0]    init_cnt_d;
    logic             rr_pri_q;
    logic             rf_we_q;
    logic [WIDTH-1:0] rf_w_addr_q;
    logic [WIDTH-1:0] rf_in_q;
    logic [NREQ-1:0]  grant_q;

    logic [NREQ-1:0]  arb_grant;
    logic             xfer;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;

    rr_arbiter2 u_arb (
        .req_valid_i (req_valid),
        .rr_pri_i    (rr_pri_q),
        .grant_o     (arb_grant)
    );

    // Requesters see no acceptance until the zeroing sweep has finished.
    assign req_ready = (state_q == RUN) ? arb_grant : '0;
    assign init_busy = (state_q == INIT);

    always_comb begin
        init_cnt_d = init_cnt_q + AW'(1);
        xfer       = |req_ready;
        sel_addr   = req_ready[REQ_MEM] ? req_addr_1 : req_addr_0;
        sel_data   = req_ready[REQ_MEM] ? req_data_1 : req_data_0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            init_cnt_q  <= AW'(1);
            rr_pri_q    <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_w_addr_q <= '0;
            rf_in_q     <= '0;
            grant_q     <= '0;
        end else begin
            unique case (state_q)
                INIT: begin
                    rf_we_q     <= 1'b1;
                    rf_w_addr_q <= {{(WIDTH-AW){1'b0}}, init_cnt_q};
                    rf_in_q     <= '0;
                    grant_q     <= '0;
                    init_cnt_q  <= init_cnt_d;
                    if (init_cnt_q == LAST_ADDR) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    grant_q <= req_ready;
                    // x0 is hard-wired: the handshake completes but no write is issued.
                    rf_we_q <= xfer && (sel_addr != '0);
                    if (xfer) begin
                        rf_w_addr_q <= {{(WIDTH-AW){1'b0}}, sel_addr};
                        rf_in_q     <= sel_data;
                        rr_pri_q    <= req_ready[REQ_EXEC];
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_w_addr = rf_w_addr_q;
    assign rf_in     = rf_in_q;
    assign grant     = grant_q;

endmodule : regfile_write_sched
`default_nettype wire

// File: tb/tb_regfile_write_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_sched
// Brief    : Directed self-checking bench with expected-write scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_sched;

    localparam int WIDTH = 32;
    localparam int REGNO = 32;
    localparam int AW    = 5;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [AW-1:0]    req_addr_0;
    logic [AW-1:0]    req_addr_1;
    logic [WIDTH-1:0] req_data_0;
    logic [WIDTH-1:0] req_data_1;
    logic             init_busy;
    logic [1:0]       grant;
    logic             rf_we;
    logic [WIDTH-1:0] rf_w_addr;
    logic [WIDTH-1:0] rf_in;

    regfile_write_sched #(.WIDTH(WIDTH), .REGNO(REGNO), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr_0 (req_addr_0),
        .req_addr_1 (req_addr_1),
        .req_data_0 (req_data_0),
        .req_data_1 (req_data_1),
        .init_busy  (init_busy),
        .grant      (grant),
        .rf_we      (rf_we),
        .rf_w_addr  (rf_w_addr),
        .rf_in      (rf_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  grant;
    } wr_t;

    wr_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic we, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] g);
        wr_t e;
        e.we = we; e.addr = a; e.data = d; e.grant = g;
        sb.push_back(e);
    endtask

    // Advance one posedge and compare registered outputs against the oldest expectation.
    task automatic clk_and_check(input string tag);
        wr_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".we"}, 64'(rf_we), 64'(e.we));
            chk({tag, ".grant"}, 64'(grant), 64'(e.grant));
            if (e.we) begin
                chk({tag, ".addr"}, 64'(rf_w_addr), 64'(e.addr));
                chk({tag, ".data"}, 64'(rf_in), 64'(e.data));
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".we"}, 64'(rf_we), 64'd0);
        chk({tag, ".addr"}, 64'(rf_w_addr), 64'd0);
        chk({tag, ".data"}, 64'(rf_in), 64'd0);
        chk({tag, ".grant"}, 64'(grant), 64'd0);
        chk({tag, ".busy"}, 64'(init_busy), 64'd1);
        chk({tag, ".ready"}, 64'(req_ready), 64'd0);
    endtask

    // Called at a negedge; returns at the negedge after the last sweep write.
    task automatic sweep(input string tag, input int last);
        for (int k = 1; k <= last; k++) begin
            chk({tag, ".busy"}, 64'(init_busy), 64'd1);
            chk({tag, ".ready"}, 64'(req_ready), 64'd0);
            expect_wr(1'b1, 32'(k), 32'd0, 2'b00);
            clk_and_check(tag);
            @(negedge clk);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_addr_0 = '0;
        req_addr_1 = '0;
        req_data_0 = '0;
        req_data_1 = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");

        // Idle sweep: exactly 31 busy cycles writing x1..x31 with zero
        @(negedge clk);
        rst = 1'b0;
        sweep("sweep1", REGNO - 1);
        chk("sweep1.busy_drop", 64'(init_busy), 64'd0);
        expect_wr(1'b0, 32'd0, 32'd0, 2'b00);
        clk_and_check("idle1");
        chk("idle1.addr_hold", 64'(rf_w_addr), 64'd31);
        chk("idle1.data_hold", 64'(rf_in), 64'd0);

        // Requester 0 alone
        @(negedge clk);
        req_valid  = 2'b01;
        req_addr_0 = 5'd5;
        req_data_0 = 32'hDEADBEEF;
        #1;
        chk("single0.ready", 64'(req_ready), 64'b01);
        expect_wr(1'b1, 32'd5, 32'hDEADBEEF, 2'b01);
        clk_and_check("single0");

        // Requester 1 to x0: accepted, no write issued
        @(negedge clk);
        req_valid  = 2'b10;
        req_addr_1 = 5'd0;
        req_data_1 = 32'h1234;
        #1;
        chk("x0.ready", 64'(req_ready), 64'b10);
        expect_wr(1'b0, 32'd0, 32'd0, 2'b10);
        clk_and_check("x0");

        // Both requesters continuously valid: strict alternation starting at 0
        @(negedge clk);
        req_valid  = 2'b11;
        req_addr_0 = 5'd3;
        req_data_0 = 32'h0000_0033;
        req_addr_1 = 5'd7;
        req_data_1 = 32'h0000_0077;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("alt.ready", 64'(req_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
            if (i % 2 == 0) expect_wr(1'b1, 32'd3, 32'h33, 2'b01);
            else            expect_wr(1'b1, 32'd7, 32'h77, 2'b10);
            clk_and_check("alt");
            @(negedge clk);
        end
        req_valid = 2'b00;
        #1;
        chk("idle2.ready", 64'(req_ready), 64'd0);
        expect_wr(1'b0, 32'd0, 32'd0, 2'b00);
        clk_and_check("idle2");
        chk("idle2.addr_hold", 64'(rf_w_addr), 64'd7);
        chk("idle2.data_hold", 64'(rf_in), 64'h77);

        // Reset pulse mid-sweep at address 10, with requester 0 waiting throughout
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("rst2");
        @(negedge clk);
        rst = 1'b0;
        sweep("sweep2a", 10);
        chk("sweep2a.addr10", 64'(rf_w_addr), 64'd10);
        rst        = 1'b1;
        req_valid  = 2'b01;
        req_addr_0 = 5'd9;
        req_data_0 = 32'h0000_00A5;
        @(posedge clk);
        #1;
        check_reset_state("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        sweep("sweep2b", REGNO - 1);
        chk("run1.busy", 64'(init_busy), 64'd0);
        chk("run1.ready", 64'(req_ready), 64'b01);
        expect_wr(1'b1, 32'd9, 32'hA5, 2'b01);
        clk_and_check("run1");
        @(negedge clk);
        req_valid = 2'b00;

        chk("sb.drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_write_sched
`default_nettype wire
